// File: rtl/fft_mac_pkg.sv
// Shared types and the round/saturate helper for the radix-4 twiddle MAC datapath.
package fft_mac_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    RND_FLOOR   = 2'd0,
    RND_HALF_UP = 2'd1,
    RND_CONV    = 2'd2
  } rmode_e;

  typedef struct packed {
    logic                    sat;
    logic signed [MAX_W-1:0] val;
  } rs_t;

  // Drops lsb_drop LSBs with the requested rounding, then clamps to a signed out_w range.
  function automatic rs_t round_sat(input logic signed [MAX_W-1:0] s,
                                    input logic [1:0]              mode,
                                    input int unsigned             lsb_drop,
                                    input int unsigned             out_w);
    rs_t                     res;
    logic signed [MAX_W-1:0] h;
    logic signed [MAX_W-1:0] fmask;
    logic signed [MAX_W-1:0] frac;
    logic signed [MAX_W-1:0] fl;
    logic signed [MAX_W-1:0] up;
    logic signed [MAX_W-1:0] r;
    logic signed [MAX_W-1:0] mx;
    logic signed [MAX_W-1:0] mn;
    h     = MAX_W'(1) << (lsb_drop - 1);
    fmask = (h + h) - MAX_W'(1);
    frac  = s & fmask;
    fl    = s >>> lsb_drop;
    up    = (s + h) >>> lsb_drop;
    case (mode)
      RND_FLOOR: r = fl;
      RND_CONV:  r = (frac == h) ? fl + {{(MAX_W-1){1'b0}}, fl[0]} : up;
      default:   r = up;
    endcase
    mx        = (MAX_W'(1) << (out_w - 1)) - MAX_W'(1);
    mn        = ~mx;
    res.sat   = 1'b0;
    res.val   = r;
    if (r > mx) begin
      res.val = mx;
      res.sat = 1'b1;
    end else if (r < mn) begin
      res.val = mn;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cplx_mul_pipe.sv
// Registered full-precision complex multiplier; conj negates the imaginary part of b.
module cplx_mul_pipe
#(
  parameter int unsigned A_W = 21,
  parameter int unsigned B_W = 16,
  parameter int unsigned P_W = 39
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  conj,
  input  logic signed [A_W-1:0] ar,
  input  logic signed [A_W-1:0] ai,
  input  logic signed [B_W-1:0] br,
  input  logic signed [B_W-1:0] bi,
  output logic signed [P_W-1:0] pr,
  output logic signed [P_W-1:0] pi
);

  localparam logic signed [B_W-1:0] B_MIN = {1'b1, {(B_W-1){1'b0}}};
  localparam logic signed [B_W-1:0] B_MAX = ~B_MIN;

  logic signed [B_W-1:0] bi_c;
  logic signed [P_W-1:0] arx_c, aix_c, brx_c, bix_c;
  logic signed [P_W-1:0] pr_d, pr_q, pi_d, pi_q;

  // The most negative twiddle has no positive twin, so it maps to the max value.
  always_comb begin
    bi_c = bi;
    if (conj) begin
      bi_c = (bi == B_MIN) ? B_MAX : -bi;
    end
    arx_c = {{(P_W-A_W){ar[A_W-1]}}, ar};
    aix_c = {{(P_W-A_W){ai[A_W-1]}}, ai};
    brx_c = {{(P_W-B_W){br[B_W-1]}}, br};
    bix_c = {{(P_W-B_W){bi_c[B_W-1]}}, bi_c};
  end

  always_comb begin
    pr_d = pr_q;
    pi_d = pi_q;
    if (en) begin
      pr_d = (arx_c * brx_c) - (aix_c * bix_c);
      pi_d = (arx_c * bix_c) + (aix_c * brx_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr_q <= '0;
      pi_q <= '0;
    end else begin
      pr_q <= pr_d;
      pi_q <= pi_d;
    end
  end

  assign pr = pr_q;
  assign pi = pi_q;

endmodule

// File: rtl/param_radix4_twiddle_mac.sv
// Radix-4 DIT twiddle multiply-accumulate: y[i] = x0*2^TW_FRAC + sum_k x[k]*W[k][i],
// four-stage elastic pipeline with per-beat rounding mode, inverse mode and saturation flags.
module param_radix4_twiddle_mac
  import fft_mac_pkg::*;
#(
  parameter int unsigned DATA_W   = 21,
  parameter int unsigned TW_W     = 16,
  parameter int unsigned TW_FRAC  = 15,
  parameter int unsigned LSB_DROP = 10,
  parameter int unsigned OUT_W    = 27,
  parameter int unsigned LBL_W    = 11
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inv,
  input  logic [1:0]           in_rmode,
  input  logic [LBL_W-1:0]     in_label,
  input  logic [4*DATA_W-1:0]  x_r,
  input  logic [4*DATA_W-1:0]  x_i,
  input  logic [12*TW_W-1:0]   tw_r,
  input  logic [12*TW_W-1:0]   tw_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*OUT_W-1:0]   y_r,
  output logic [4*OUT_W-1:0]   y_i,
  output logic [LBL_W-1:0]     out_label,
  output logic                 out_sat,
  output logic                 sat_sticky,
  input  logic                 sat_clr
);

  localparam int unsigned ACC_W = DATA_W + TW_W + 2;
  localparam int unsigned NPROD = 12;

  logic en_c;

  // Stage 1: input register
  logic                v1_d, v1_q, inv1_d, inv1_q;
  logic [1:0]          rm1_d, rm1_q;
  logic [LBL_W-1:0]    lbl1_d, lbl1_q;
  logic [4*DATA_W-1:0] xr1_d, xr1_q, xi1_d, xi1_q;
  logic [12*TW_W-1:0]  twr1_d, twr1_q, twi1_d, twi1_q;

  // Stage 2: products and aligned x0
  logic                    v2_d, v2_q;
  logic [1:0]              rm2_d, rm2_q;
  logic [LBL_W-1:0]        lbl2_d, lbl2_q;
  logic signed [ACC_W-1:0] x0r2_d, x0r2_q, x0i2_d, x0i2_q;
  logic signed [ACC_W-1:0] prod_r [NPROD];
  logic signed [ACC_W-1:0] prod_i [NPROD];

  // Stage 3: four-term sums
  logic                    v3_d, v3_q;
  logic [1:0]              rm3_d, rm3_q;
  logic [LBL_W-1:0]        lbl3_d, lbl3_q;
  logic signed [ACC_W-1:0] sr3_d [4];
  logic signed [ACC_W-1:0] sr3_q [4];
  logic signed [ACC_W-1:0] si3_d [4];
  logic signed [ACC_W-1:0] si3_q [4];

  // Stage 4: rounded, saturated output
  logic [4*OUT_W-1:0] yr_c, yi_c;
  logic               sat_c;
  logic               out_valid_d, out_valid_q, out_sat_d, out_sat_q;
  logic               sat_sticky_d, sat_sticky_q;
  logic [LBL_W-1:0]   out_label_d, out_label_q;
  logic [4*OUT_W-1:0] y_r_d, y_r_q, y_i_d, y_i_q;

  // Whole pipeline advances together; holds only when the output beat is refused.
  assign en_c     = ~(out_valid_q & ~out_ready);
  assign in_ready = en_c;

  always_comb begin
    v1_d   = v1_q;
    inv1_d = inv1_q;
    rm1_d  = rm1_q;
    lbl1_d = lbl1_q;
    xr1_d  = xr1_q;
    xi1_d  = xi1_q;
    twr1_d = twr1_q;
    twi1_d = twi1_q;
    if (en_c) begin
      v1_d   = in_valid;
      inv1_d = in_inv;
      rm1_d  = in_rmode;
      lbl1_d = in_label;
      xr1_d  = x_r;
      xi1_d  = x_i;
      twr1_d = tw_r;
      twi1_d = tw_i;
    end
  end

  for (genvar k = 1; k < 4; k++) begin : g_k
    for (genvar i = 0; i < 4; i++) begin : g_i
      cplx_mul_pipe #(
        .A_W (DATA_W),
        .B_W (TW_W),
        .P_W (ACC_W)
      ) u_mul (
        .clk  (clk),
        .rst  (rst),
        .en   (en_c),
        .conj (inv1_q),
        .ar   (xr1_q[k*DATA_W +: DATA_W]),
        .ai   (xi1_q[k*DATA_W +: DATA_W]),
        .br   (twr1_q[((k-1)*4+i)*TW_W +: TW_W]),
        .bi   (twi1_q[((k-1)*4+i)*TW_W +: TW_W]),
        .pr   (prod_r[(k-1)*4+i]),
        .pi   (prod_i[(k-1)*4+i])
      );
    end
  end

  always_comb begin
    v2_d   = v2_q;
    rm2_d  = rm2_q;
    lbl2_d = lbl2_q;
    x0r2_d = x0r2_q;
    x0i2_d = x0i2_q;
    if (en_c) begin
      v2_d   = v1_q;
      rm2_d  = rm1_q;
      lbl2_d = lbl1_q;
      x0r2_d = {{(ACC_W-DATA_W){xr1_q[DATA_W-1]}}, xr1_q[DATA_W-1:0]} << TW_FRAC;
      x0i2_d = {{(ACC_W-DATA_W){xi1_q[DATA_W-1]}}, xi1_q[DATA_W-1:0]} << TW_FRAC;
    end
  end

  always_comb begin
    v3_d   = v3_q;
    rm3_d  = rm3_q;
    lbl3_d = lbl3_q;
    sr3_d  = sr3_q;
    si3_d  = si3_q;
    if (en_c) begin
      v3_d   = v2_q;
      rm3_d  = rm2_q;
      lbl3_d = lbl2_q;
      for (int i = 0; i < 4; i++) begin
        sr3_d[i] = x0r2_q + prod_r[i] + prod_r[4+i] + prod_r[8+i];
        si3_d[i] = x0i2_q + prod_i[i] + prod_i[4+i] + prod_i[8+i];
      end
    end
  end

  always_comb begin
    rs_t rs_r;
    rs_t rs_i;
    rs_r  = '0;
    rs_i  = '0;
    yr_c  = '0;
    yi_c  = '0;
    sat_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rs_r = round_sat({{(MAX_W-ACC_W){sr3_q[i][ACC_W-1]}}, sr3_q[i]}, rm3_q, LSB_DROP, OUT_W);
      rs_i = round_sat({{(MAX_W-ACC_W){si3_q[i][ACC_W-1]}}, si3_q[i]}, rm3_q, LSB_DROP, OUT_W);
      yr_c[i*OUT_W +: OUT_W] = OUT_W'(rs_r.val);
      yi_c[i*OUT_W +: OUT_W] = OUT_W'(rs_i.val);
      sat_c = sat_c | rs_r.sat | rs_i.sat;
    end
  end

  // Output data only changes when a real beat lands, so idle cycles keep the last result.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sat_d   = out_sat_q;
    out_label_d = out_label_q;
    y_r_d       = y_r_q;
    y_i_d       = y_i_q;
    if (en_c) begin
      out_valid_d = v3_q;
      if (v3_q) begin
        out_sat_d   = sat_c;
        out_label_d = lbl3_q;
        y_r_d       = yr_c;
        y_i_d       = yi_c;
      end
    end
    sat_sticky_d = (sat_sticky_q & ~sat_clr) | (out_valid_q & out_ready & out_sat_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q         <= 1'b0;
      inv1_q       <= 1'b0;
      rm1_q        <= '0;
      lbl1_q       <= '0;
      xr1_q        <= '0;
      xi1_q        <= '0;
      twr1_q       <= '0;
      twi1_q       <= '0;
      v2_q         <= 1'b0;
      rm2_q        <= '0;
      lbl2_q       <= '0;
      x0r2_q       <= '0;
      x0i2_q       <= '0;
      v3_q         <= 1'b0;
      rm3_q        <= '0;
      lbl3_q       <= '0;
      for (int i = 0; i < 4; i++) begin
        sr3_q[i] <= '0;
        si3_q[i] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_sat_q    <= 1'b0;
      out_label_q  <= '0;
      y_r_q        <= '0;
      y_i_q        <= '0;
      sat_sticky_q <= 1'b0;
    end else begin
      v1_q         <= v1_d;
      inv1_q       <= inv1_d;
      rm1_q        <= rm1_d;
      lbl1_q       <= lbl1_d;
      xr1_q        <= xr1_d;
      xi1_q        <= xi1_d;
      twr1_q       <= twr1_d;
      twi1_q       <= twi1_d;
      v2_q         <= v2_d;
      rm2_q        <= rm2_d;
      lbl2_q       <= lbl2_d;
      x0r2_q       <= x0r2_d;
      x0i2_q       <= x0i2_d;
      v3_q         <= v3_d;
      rm3_q        <= rm3_d;
      lbl3_q       <= lbl3_d;
      sr3_q        <= sr3_d;
      si3_q        <= si3_d;
      out_valid_q  <= out_valid_d;
      out_sat_q    <= out_sat_d;
      out_label_q  <= out_label_d;
      y_r_q        <= y_r_d;
      y_i_q        <= y_i_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sat    = out_sat_q;
  assign out_label  = out_label_q;
  assign y_r        = y_r_q;
  assign y_i        = y_i_q;
  assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_param_radix4_twiddle_mac.sv
// Bench for param_radix4_twiddle_mac: directed scenarios plus a randomized stream
// checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_param_radix4_twiddle_mac;

  localparam int DW  = 21;
  localparam int TWW = 16;
  localparam int OW  = 27;
  localparam int LW  = 11;
  localparam longint YMAX = 67108863;
  localparam longint YMIN = -67108864;

  typedef struct packed {
    logic             inv;
    logic [1:0]       rmode;
    logic [LW-1:0]    label;
    logic [4*DW-1:0]  xr;
    logic [4*DW-1:0]  xi;
    logic [12*TWW-1:0] twr;
    logic [12*TWW-1:0] twi;
  } beat_t;

  typedef struct packed {
    logic [LW-1:0]   label;
    logic            sat;
    logic [4*OW-1:0] yr;
    logic [4*OW-1:0] yi;
  } res_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, in_inv;
  logic [1:0]        in_rmode;
  logic [LW-1:0]     in_label;
  logic [4*DW-1:0]   x_r, x_i;
  logic [12*TWW-1:0] tw_r, tw_i;
  logic              out_valid, out_ready;
  logic [4*OW-1:0]   y_r, y_i;
  logic [LW-1:0]     out_label;
  logic              out_sat, sat_sticky, sat_clr;

  param_radix4_twiddle_mac dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inv     (in_inv),
    .in_rmode   (in_rmode),
    .in_label   (in_label),
    .x_r        (x_r),
    .x_i        (x_i),
    .tw_r       (tw_r),
    .tw_i       (tw_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y_r        (y_r),
    .y_i        (y_i),
    .out_label  (out_label),
    .out_sat    (out_sat),
    .sat_sticky (sat_sticky),
    .sat_clr    (sat_clr)
  );

  always #5 clk = ~clk;

  int    nchk = 0;
  int    nerr = 0;
  int    cyc = 0;
  int    rdy_bad = 0;
  res_t  exp_q[$];
  res_t  got_q[$];
  int    acc_cyc[$];
  int    got_cyc[$];
  beat_t idle_b;

  function automatic longint rnd(input longint s, input logic [1:0] m);
    longint fl, fr;
    fl = s >>> 10;
    fr = s - fl * 1024;
    if (m == 2'd0) return fl;
    if (m == 2'd2) begin
      if (fr > 512) return fl + 1;
      if (fr == 512) return ((fl % 2) != 0) ? fl + 1 : fl;
      return fl;
    end
    return (fr >= 512) ? fl + 1 : fl;
  endfunction

  function automatic res_t model(input beat_t b);
    res_t   r;
    longint s[2];
    longint ar, ai, br, bi, q;
    r.label = b.label;
    r.sat   = 1'b0;
    r.yr    = '0;
    r.yi    = '0;
    for (int i = 0; i < 4; i++) begin
      ar   = $signed(b.xr[0 +: DW]);
      ai   = $signed(b.xi[0 +: DW]);
      s[0] = ar * 32768;
      s[1] = ai * 32768;
      for (int k = 1; k < 4; k++) begin
        ar = $signed(b.xr[k*DW +: DW]);
        ai = $signed(b.xi[k*DW +: DW]);
        br = $signed(b.twr[((k-1)*4+i)*TWW +: TWW]);
        bi = $signed(b.twi[((k-1)*4+i)*TWW +: TWW]);
        if (b.inv) bi = (bi == -32768) ? 32767 : -bi;
        s[0] += ar * br - ai * bi;
        s[1] += ar * bi + ai * br;
      end
      for (int c = 0; c < 2; c++) begin
        q = rnd(s[c], b.rmode);
        if (q > YMAX) begin q = YMAX; r.sat = 1'b1; end
        else if (q < YMIN) begin q = YMIN; r.sat = 1'b1; end
        if (c == 0) r.yr[i*OW +: OW] = q[OW-1:0];
        else        r.yi[i*OW +: OW] = q[OW-1:0];
      end
    end
    return r;
  endfunction

  function automatic beat_t rand_beat(input logic [LW-1:0] lbl);
    beat_t                 b;
    logic signed [DW-1:0]  xv;
    logic signed [TWW-1:0] tv;
    b.inv   = 1'($urandom);
    b.rmode = 2'($urandom);
    b.label = lbl;
    for (int k = 0; k < 4; k++) begin
      xv = DW'($urandom);
      xv = xv >>> $urandom_range(0, 10);
      b.xr[k*DW +: DW] = xv;
      xv = DW'($urandom);
      xv = xv >>> $urandom_range(0, 10);
      b.xi[k*DW +: DW] = xv;
    end
    for (int j = 0; j < 12; j++) begin
      tv = ($urandom_range(0, 7) == 0) ? 16'h8000 : TWW'($urandom);
      b.twr[j*TWW +: TWW] = tv;
      tv = ($urandom_range(0, 7) == 0) ? 16'h8000 : TWW'($urandom);
      b.twi[j*TWW +: TWW] = tv;
    end
    return b;
  endfunction

  // One clock of stimulus: drive at the falling edge, record what the next rising edge transfers.
  task automatic cycle(input bit iv, input beat_t b, input bit ordy, output bit acc);
    res_t g;
    bit   rexp;
    @(negedge clk);
    cyc++;
    out_ready = ordy;
    in_valid  = iv;
    in_inv    = b.inv;
    in_rmode  = b.rmode;
    in_label  = b.label;
    x_r       = b.xr;
    x_i       = b.xi;
    tw_r      = b.twr;
    tw_i      = b.twi;
    #1;
    rexp = !(out_valid && !ordy);
    if (in_ready !== rexp) rdy_bad++;
    if (out_valid === 1'b1 && ordy) begin
      g.label = out_label;
      g.sat   = out_sat;
      g.yr    = y_r;
      g.yi    = y_i;
      got_q.push_back(g);
      got_cyc.push_back(cyc);
    end
    acc = iv && rexp;
    if (acc) begin
      exp_q.push_back(model(b));
      acc_cyc.push_back(cyc);
    end
  endtask

  task automatic drain(input bit rand_rdy);
    bit acc;
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      cycle(1'b0, idle_b, rand_rdy ? 1'($urandom) : 1'b1, acc);
      n++;
    end
    repeat (3) cycle(1'b0, idle_b, 1'b1, acc);
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    acc_cyc.delete();
    got_cyc.delete();
    rdy_bad = 0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    in_inv    = 1'b0;
    in_rmode  = '0;
    in_label  = '0;
    x_r       = '0;
    x_i       = '0;
    tw_r      = '0;
    tw_i      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    nchk++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    nchk++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    nchk++;
    if ({out_sat, sat_sticky} !== 2'b00) begin nerr++; $display("FAIL reset_flags got=%b exp=00", {out_sat, sat_sticky}); end
    nchk++;
    if (y_r !== '0 || y_i !== '0) begin nerr++; $display("FAIL reset_y got_r=%h got_i=%h exp=0", y_r, y_i); end
    nchk++;
    if (out_label !== '0) begin nerr++; $display("FAIL reset_label got=%0d exp=0", out_label); end
  endtask

  task automatic test_x0_align();
    beat_t b;
    res_t  g;
    bit    acc;
    clear_q();
    b = rand_beat(11'd5);
    b.xr = '0;
    b.xi = '0;
    b.xr[0 +: DW] = DW'(1000);
    b.rmode = 2'd0;
    b.inv = 1'b0;
    cycle(1'b1, b, 1'b1, acc);
    drain(1'b0);
    nchk++;
    if (got_q.size() != 1) begin
      nerr++; $display("FAIL x0_count got=%0d exp=1", got_q.size());
      return;
    end
    g = got_q[0];
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (int'($signed(g.yr[i*OW +: OW])) != 32000 || int'($signed(g.yi[i*OW +: OW])) != 0)
      begin
        nerr++;
        $display("FAIL x0_y%0d got=(%0d,%0d) exp=(32000,0)", i,
                 $signed(g.yr[i*OW +: OW]), $signed(g.yi[i*OW +: OW]));
      end
    end
    nchk++;
    if (g.sat !== 1'b0 || g.label !== 11'd5) begin nerr++; $display("FAIL x0_sat_label got=%b/%0d exp=0/5", g.sat, g.label); end
    nchk++;
    if (got_cyc[0] - acc_cyc[0] != 4) begin nerr++; $display("FAIL x0_latency got=%0d exp=4", got_cyc[0] - acc_cyc[0]); end
  endtask

  task automatic test_fwd_inv();
    beat_t a, b;
    res_t  g;
    bit    acc;
    int    er[2], ei[2];
    clear_q();
    a = '0;
    a.xr[1*DW +: DW] = DW'(1000);
    for (int i = 0; i < 4; i++) a.twr[i*TWW +: TWW] = 16'd32767;
    a.label = 11'd1;
    b = '0;
    b.xr[1*DW +: DW] = DW'(1000);
    for (int i = 0; i < 4; i++) b.twi[i*TWW +: TWW] = 16'd32767;
    b.inv = 1'b1;
    b.rmode = 2'd1;
    b.label = 11'd2;
    er[0] = 31999; ei[0] = 0;
    er[1] = 0;     ei[1] = -31999;
    cycle(1'b1, a, 1'b1, acc);
    cycle(1'b1, b, 1'b1, acc);
    drain(1'b0);
    nchk++;
    if (got_q.size() != 2) begin
      nerr++; $display("FAIL fwdinv_count got=%0d exp=2", got_q.size());
      return;
    end
    for (int n = 0; n < 2; n++) begin
      g = got_q[n];
      for (int i = 0; i < 4; i++) begin
        nchk++;
        if (int'($signed(g.yr[i*OW +: OW])) != er[n] || int'($signed(g.yi[i*OW +: OW])) != ei[n])
        begin
          nerr++;
          $display("FAIL fwdinv_beat%0d_y%0d got=(%0d,%0d) exp=(%0d,%0d)", n, i,
                   $signed(g.yr[i*OW +: OW]), $signed(g.yi[i*OW +: OW]), er[n], ei[n]);
        end
      end
    end
  endtask

  task automatic test_rounding();
    beat_t b;
    res_t  g;
    bit    acc;
    int    expv[6];
    clear_q();
    expv = '{0, 1, 0, -1, 0, 0};
    for (int n = 0; n < 6; n++) begin
      b = '0;
      b.xr[1*DW +: DW] = (n < 3) ? DW'(1) : DW'(-1);
      b.twr[0 +: TWW] = 16'd512;
      b.rmode = 2'(n % 3);
      b.label = 11'(n);
      cycle(1'b1, b, 1'b1, acc);
    end
    drain(1'b0);
    nchk++;
    if (got_q.size() != 6) begin
      nerr++; $display("FAIL round_count got=%0d exp=6", got_q.size());
      return;
    end
    for (int n = 0; n < 6; n++) begin
      g = got_q[n];
      nchk++;
      if (int'($signed(g.yr[0 +: OW])) != expv[n] || int'($signed(g.yi[0 +: OW])) != 0) begin
        nerr++;
        $display("FAIL round_case%0d got=(%0d,%0d) exp=(%0d,0)", n,
                 $signed(g.yr[0 +: OW]), $signed(g.yi[0 +: OW]), expv[n]);
      end
    end
  endtask

  task automatic test_saturation_sticky();
    beat_t b;
    res_t  g;
    bit    acc;
    clear_q();
    b = '0;
    for (int k = 0; k < 4; k++) begin
      b.xr[k*DW +: DW] = DW'(1048575);
      b.xi[k*DW +: DW] = DW'(1048575);
    end
    for (int j = 0; j < 12; j++) b.twr[j*TWW +: TWW] = 16'd32767;
    b.label = 11'd7;
    nchk++;
    if (sat_sticky !== 1'b0) begin nerr++; $display("FAIL sticky_pre got=%b exp=0", sat_sticky); end
    cycle(1'b1, b, 1'b1, acc);
    drain(1'b0);
    nchk++;
    if (got_q.size() != 1) begin
      nerr++; $display("FAIL sat_count got=%0d exp=1", got_q.size());
      return;
    end
    g = got_q[0];
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (int'($signed(g.yr[i*OW +: OW])) != 67108863 || int'($signed(g.yi[i*OW +: OW])) != 67108863)
      begin
        nerr++;
        $display("FAIL sat_y%0d got=(%0d,%0d) exp=(67108863,67108863)", i,
                 $signed(g.yr[i*OW +: OW]), $signed(g.yi[i*OW +: OW]));
      end
    end
    nchk++;
    if (g.sat !== 1'b1) begin nerr++; $display("FAIL sat_flag got=%b exp=1", g.sat); end
    repeat (5) cycle(1'b0, idle_b, 1'b1, acc);
    nchk++;
    if (sat_sticky !== 1'b1) begin nerr++; $display("FAIL sticky_hold got=%b exp=1", sat_sticky); end
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    nchk++;
    if (sat_sticky !== 1'b0) begin nerr++; $display("FAIL sticky_clear got=%b exp=0", sat_sticky); end
    // Saturating beat held at the output, then consumed in the same cycle as a clear.
    cycle(1'b1, b, 1'b0, acc);
    repeat (5) cycle(1'b0, idle_b, 1'b0, acc);
    nchk++;
    if (sat_sticky !== 1'b0 || out_valid !== 1'b1) begin
      nerr++; $display("FAIL sticky_stalled got=%b/%b exp=0/1", sat_sticky, out_valid);
    end
    sat_clr = 1'b1;
    cycle(1'b0, idle_b, 1'b1, acc);
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    nchk++;
    if (sat_sticky !== 1'b1) begin nerr++; $display("FAIL sticky_set_wins got=%b exp=1", sat_sticky); end
    drain(1'b0);
    clear_q();
  endtask

  task automatic test_back_to_back();
    beat_t b;
    bit    acc;
    int    tries;
    clear_q();
    for (int l = 0; l < 20; l++) begin
      b = rand_beat(11'(l));
      acc = 1'b0;
      tries = 0;
      while (!acc && tries < 50) begin
        cycle(1'b1, b, 1'($urandom), acc);
        tries++;
      end
    end
    drain(1'b1);
    nchk++;
    if (got_q.size() != 20 || exp_q.size() != 20) begin
      nerr++; $display("FAIL b2b_count got=%0d exp=20 (accepted=%0d)", got_q.size(), exp_q.size());
    end
    for (int n = 0; n < 20 && n < got_q.size() && n < exp_q.size(); n++) begin
      nchk++;
      if (got_q[n] !== exp_q[n] || got_q[n].label !== 11'(n)) begin
        nerr++;
        $display("FAIL b2b_beat%0d got lbl=%0d sat=%b yr=%h yi=%h exp lbl=%0d sat=%b yr=%h yi=%h",
                 n, got_q[n].label, got_q[n].sat, got_q[n].yr, got_q[n].yi,
                 exp_q[n].label, exp_q[n].sat, exp_q[n].yr, exp_q[n].yi);
      end
    end
    nchk++;
    if (rdy_bad != 0) begin nerr++; $display("FAIL b2b_in_ready bad_cycles=%0d exp=0", rdy_bad); end
  endtask

  task automatic test_random_stream();
    beat_t b;
    bit    acc;
    clear_q();
    for (int l = 0; l < 40; l++) begin
      b = rand_beat(11'(100 + l));
      cycle(1'($urandom_range(0, 3) != 0), b, 1'b1, acc);
    end
    drain(1'b0);
    nchk++;
    if (got_q.size() != exp_q.size()) begin
      nerr++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int n = 0; n < got_q.size() && n < exp_q.size(); n++) begin
      nchk++;
      if (got_q[n] !== exp_q[n] || got_cyc[n] - acc_cyc[n] != 4) begin
        nerr++;
        $display("FAIL rand_beat%0d got lbl=%0d yr=%h yi=%h lat=%0d exp lbl=%0d yr=%h yi=%h lat=4",
                 n, got_q[n].label, got_q[n].yr, got_q[n].yi, got_cyc[n] - acc_cyc[n],
                 exp_q[n].label, exp_q[n].yr, exp_q[n].yi);
      end
    end
  endtask

  task automatic test_reset_midflight();
    beat_t b;
    bit    acc;
    clear_q();
    for (int l = 0; l < 4; l++) cycle(1'b1, rand_beat(11'(200 + l)), 1'b1, acc);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    nchk++;
    if (out_valid !== 1'b0 || out_sat !== 1'b0) begin
      nerr++; $display("FAIL midrst_out got=%b/%b exp=0/0", out_valid, out_sat);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_q();
    repeat (8) cycle(1'b0, idle_b, 1'b1, acc);
    nchk++;
    if (got_q.size() != 0) begin nerr++; $display("FAIL midrst_stale got=%0d exp=0", got_q.size()); end
    b = rand_beat(11'd300);
    cycle(1'b1, b, 1'b1, acc);
    drain(1'b0);
    nchk++;
    if (got_q.size() != 1) begin
      nerr++; $display("FAIL midrst_count got=%0d exp=1", got_q.size());
      return;
    end
    nchk++;
    if (got_q[0] !== exp_q[0] || got_cyc[0] - acc_cyc[0] != 4) begin
      nerr++;
      $display("FAIL midrst_beat got lbl=%0d yr=%h lat=%0d exp lbl=%0d yr=%h lat=4",
               got_q[0].label, got_q[0].yr, got_cyc[0] - acc_cyc[0], exp_q[0].label, exp_q[0].yr);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle_b = '0;
    test_reset();
    test_x0_align();
    test_fwd_inv();
    test_rounding();
    test_saturation_sticky();
    test_back_to_back();
    test_random_stream();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
